// File: rtl/a2s_pkg.sv
// rtl/a2s_pkg.sv - shared types and helpers for the AXI-to-stream reader
package a2s_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_AR    = 2'd1,
        S_R     = 2'd2,
        S_DRAIN = 2'd3
    } a2s_state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    // Index width for n entries, never narrower than one bit
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/a2s_stream_reader_if.sv
// rtl/a2s_stream_reader_if.sv - AXI read address/data channels of the stream reader
interface a2s_stream_reader_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] AXI_araddr;
    logic [7:0]        AXI_arlen;
    logic [2:0]        AXI_arsize;
    logic [1:0]        AXI_arburst;
    logic              AXI_arvalid;
    logic              AXI_arready;
    logic              AXI_rvalid;
    logic              AXI_rready;
    logic              AXI_rlast;
    logic [1:0]        AXI_rresp;

    modport master (
        output AXI_araddr, AXI_arlen, AXI_arsize, AXI_arburst, AXI_arvalid, AXI_rready,
        input  AXI_arready, AXI_rvalid, AXI_rlast, AXI_rresp
    );

    modport slave (
        input  AXI_araddr, AXI_arlen, AXI_arsize, AXI_arburst, AXI_arvalid, AXI_rready,
        output AXI_arready, AXI_rvalid, AXI_rlast, AXI_rresp
    );
endinterface

// File: rtl/a2s_slot_tracker.sv
// rtl/a2s_slot_tracker.sv - local buffer slot occupancy, read pointer and fetch credit
module a2s_slot_tracker
    import a2s_pkg::*;
#(
    parameter int BURST_LEN = 16,
    parameter int NBUF      = 2,
    parameter int BB        = width_of(BURST_LEN),
    parameter int SB        = width_of(NBUF)
) (
    input  logic          Sclk,
    input  logic          rst,
    input  logic          clear,
    input  logic          fill,
    input  logic          inflight,
    input  logic          take,
    output logic          credit,
    output logic          ovalid,
    output logic          rel,
    output logic [SB-1:0] wslot,
    output logic [SB-1:0] rslot,
    output logic [BB-1:0] rbeat
);
    logic [SB:0] fill_cnt;
    logic [SB:0] fill_cnt_d;
    logic        consume;

    assign consume = take & ovalid;
    assign rel     = consume & (rbeat == BB'(BURST_LEN - 1));
    assign credit  = ({1'b0, fill_cnt} + (SB+2)'(inflight)) < (SB+2)'(NBUF);

    // A fill and a release landing together leave occupancy unchanged
    always_comb begin
        fill_cnt_d = fill_cnt;
        if (fill && !rel)
            fill_cnt_d = fill_cnt + 1'b1;
        else if (rel && !fill)
            fill_cnt_d = fill_cnt - 1'b1;
    end

    always_ff @(posedge Sclk or posedge rst) begin
        if (rst) begin
            fill_cnt <= '0;
            ovalid   <= 1'b0;
            wslot    <= '0;
            rslot    <= '0;
            rbeat    <= '0;
        end else if (clear) begin
            fill_cnt <= '0;
            ovalid   <= 1'b0;
            wslot    <= '0;
            rslot    <= '0;
            rbeat    <= '0;
        end else begin
            fill_cnt <= fill_cnt_d;
            ovalid   <= (fill_cnt_d != '0);
            if (fill)
                wslot <= wslot + 1'b1;
            if (consume)
                rbeat <= rbeat + 1'b1;
            if (rel)
                rslot <= rslot + 1'b1;
        end
    end
endmodule

// File: rtl/a2s_stream_reader.sv
// rtl/a2s_stream_reader.sv - burst fetch engine from a circular memory region into a slotted buffer
module a2s_stream_reader
    import a2s_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int BEAT_BYTES = 4,
    parameter int BURST_LEN  = 16,
    parameter int NBUF       = 2,
    parameter int SIZE_W     = 18,
    parameter int BB         = width_of(BURST_LEN),
    parameter int SB         = width_of(NBUF)
) (
    input  logic                Sclk,
    input  logic                rst,
    input  logic                sync,
    input  logic [ADDR_W-1:0]   obase,
    input  logic [SIZE_W-1:0]   osize,
    input  logic                loop,
    input  logic                Oen,
    output logic [SB+BB-1:0]    Oaddr,
    output logic                Ovalid,
    output logic [SIZE_W-1:0]   oacnt,
    output logic [31:0]         obcnt,
    output logic                underrun,
    output logic                err,
    output logic                done,
    a2s_stream_reader_if.master axi,
    output logic [SB+BB-1:0]    a2s_addr,
    output logic                a2s_en
);
    localparam int BURST_BYTES = BURST_LEN * BEAT_BYTES;
    localparam int OFF_W       = width_of(BURST_BYTES);

    a2s_state_t        state_q, state_d;
    logic              arvalid_q, arvalid_d;
    logic              rready_q, rready_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic [SIZE_W-1:0] fidx_q, fidx_d;
    logic [BB-1:0]     wbeat_q, wbeat_d;
    logic              abort_q, abort_d;
    logic [SIZE_W-1:0] oacnt_q;
    logic [31:0]       obcnt_q;
    logic              underrun_q, err_q, done_q;

    logic              credit, rel, inflight, more, issue, ar_hs, last_beat, beat_bad, fill;
    logic [SB-1:0]     wslot, rslot;
    logic [BB-1:0]     rbeat;
    logic [ADDR_W-1:0] base_al, fetch_addr;

    assign base_al    = obase & ~ADDR_W'(BURST_BYTES - 1);
    assign fetch_addr = base_al + (ADDR_W'(fidx_q) << OFF_W);
    assign inflight   = (state_q == S_AR) || (state_q == S_R);
    assign more       = loop ? (osize != '0) : (fidx_q < osize);
    assign issue      = (state_q == S_IDLE) && credit && !sync && more;
    assign ar_hs      = arvalid_q && axi.AXI_arready;
    assign a2s_en     = axi.AXI_rvalid && rready_q && (state_q != S_DRAIN);
    assign last_beat  = (wbeat_q == BB'(BURST_LEN - 1));
    assign beat_bad   = (axi.AXI_rresp != 2'b00) || (axi.AXI_rlast != last_beat);
    assign fill       = (state_q == S_R) && a2s_en && axi.AXI_rlast && !sync;

    a2s_slot_tracker #(.BURST_LEN(BURST_LEN), .NBUF(NBUF), .BB(BB), .SB(SB)) u_slots (
        .Sclk     (Sclk),
        .rst      (rst),
        .clear    (sync),
        .fill     (fill),
        .inflight (inflight),
        .take     (Oen),
        .credit   (credit),
        .ovalid   (Ovalid),
        .rel      (rel),
        .wslot    (wslot),
        .rslot    (rslot),
        .rbeat    (rbeat)
    );

    always_comb begin
        state_d   = state_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        araddr_d  = araddr_q;
        fidx_d    = fidx_q;
        wbeat_d   = wbeat_q;
        abort_d   = abort_q;
        case (state_q)
            S_IDLE: begin
                araddr_d = fetch_addr;
                if (issue) begin
                    arvalid_d = 1'b1;
                    state_d   = S_AR;
                end
            end
            S_AR: begin
                // A restart seen while the address is pending must still drain that burst
                if (sync)
                    abort_d = 1'b1;
                if (ar_hs) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    wbeat_d   = '0;
                    abort_d   = 1'b0;
                    if (sync || abort_q) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_R;
                        fidx_d  = (loop && fidx_q == osize - 1'b1) ? '0 : fidx_q + 1'b1;
                    end
                end
            end
            S_R: begin
                if (a2s_en) begin
                    wbeat_d = wbeat_q + 1'b1;
                    if (axi.AXI_rlast) begin
                        rready_d = 1'b0;
                        state_d  = S_IDLE;
                    end
                end
                if (sync && !(a2s_en && axi.AXI_rlast))
                    state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (axi.AXI_rvalid && axi.AXI_rlast) begin
                    rready_d = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (sync)
            fidx_d = '0;
    end

    always_ff @(posedge Sclk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            araddr_q  <= '0;
            fidx_q    <= '0;
            wbeat_q   <= '0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            araddr_q  <= araddr_d;
            fidx_q    <= fidx_d;
            wbeat_q   <= wbeat_d;
            abort_q   <= abort_d;
        end
    end

    always_ff @(posedge Sclk or posedge rst) begin
        if (rst) begin
            oacnt_q    <= '0;
            obcnt_q    <= '0;
            underrun_q <= 1'b0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
        end else if (sync) begin
            oacnt_q    <= '0;
            obcnt_q    <= '0;
            underrun_q <= 1'b0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            if (Oen && !Ovalid)
                underrun_q <= 1'b1;
            if ((state_q == S_R) && a2s_en && beat_bad)
                err_q <= 1'b1;
            if (rel) begin
                if (oacnt_q == osize - 1'b1) begin
                    oacnt_q <= '0;
                    obcnt_q <= obcnt_q + 32'd1;
                end else begin
                    oacnt_q <= oacnt_q + 1'b1;
                end
            end
            done_q <= !loop && ((osize == '0) || (obcnt_q != 32'd0));
        end
    end

    assign axi.AXI_araddr  = araddr_q;
    assign axi.AXI_arvalid = arvalid_q;
    assign axi.AXI_rready  = rready_q;
    assign axi.AXI_arlen   = 8'(BURST_LEN - 1);
    assign axi.AXI_arsize  = 3'($clog2(BEAT_BYTES));
    assign axi.AXI_arburst = AXI_BURST_INCR;

    assign Oaddr    = {rslot, rbeat};
    assign a2s_addr = {wslot, wbeat_q};
    assign oacnt    = oacnt_q;
    assign obcnt    = obcnt_q;
    assign underrun = underrun_q;
    assign err      = err_q;
    assign done     = done_q;
endmodule

// File: tb/tb_a2s_stream_reader.sv
// tb/tb_a2s_stream_reader.sv - bench for a2s_stream_reader with AXI slave, buffer RAM and consumer model
module tb_a2s_stream_reader;
    localparam int ADDR_W     = 32;
    localparam int BEAT_BYTES = 4;
    localparam int BURST_LEN  = 16;
    localparam int NBUF       = 4;
    localparam int SIZE_W     = 18;
    localparam int AW         = $clog2(NBUF) + $clog2(BURST_LEN);

    logic              Sclk = 1'b0;
    logic              rst, sync, loop, Oen;
    logic [31:0]       obase;
    logic [SIZE_W-1:0] osize;
    logic [AW-1:0]     Oaddr, a2s_addr;
    logic              Ovalid, underrun, err, done, a2s_en;
    logic [SIZE_W-1:0] oacnt;
    logic [31:0]       obcnt;

    a2s_stream_reader_if #(.ADDR_W(ADDR_W)) axi();

    a2s_stream_reader #(
        .ADDR_W(ADDR_W), .BEAT_BYTES(BEAT_BYTES), .BURST_LEN(BURST_LEN),
        .NBUF(NBUF), .SIZE_W(SIZE_W)
    ) dut (
        .Sclk(Sclk), .rst(rst), .sync(sync), .obase(obase), .osize(osize), .loop(loop),
        .Oen(Oen), .Oaddr(Oaddr), .Ovalid(Ovalid), .oacnt(oacnt), .obcnt(obcnt),
        .underrun(underrun), .err(err), .done(done), .axi(axi),
        .a2s_addr(a2s_addr), .a2s_en(a2s_en)
    );

    always #5 Sclk = ~Sclk;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Slave, buffer RAM and consumer state
    logic [31:0] ar_q[$];
    logic [31:0] ar_log[$];
    logic [31:0] mem [0:(1<<AW)-1];
    int  beat_idx = 0, r_burst_no = 0, drained = 0;
    int  cons_beats = 0, cons_target = 0;
    bit  cons_en = 0, cons_rand = 0, cons_force = 0, sb_en = 0, slave_rand = 0;
    int  inj_burst = -1, inj_resp_beat = 0, inj_last = 0;

    function automatic logic [31:0] exp_ar(input int k);
        logic [31:0] base;
        base = obase & ~32'h3F;
        return base + 32'((k % int'(osize)) * BURST_LEN * BEAT_BYTES);
    endfunction

    function automatic logic [31:0] exp_tag(input int n);
        return exp_ar(n / BURST_LEN) + 32'((n % BURST_LEN) * BEAT_BYTES);
    endfunction

    initial begin
        int last_idx;
        axi.AXI_arready = 1'b0;
        axi.AXI_rvalid  = 1'b0;
        axi.AXI_rlast   = 1'b0;
        axi.AXI_rresp   = 2'd0;
        Oen = 1'b0;
        forever begin
            @(negedge Sclk);
            axi.AXI_arready = slave_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (ar_q.size() != 0) begin
                last_idx = (r_burst_no == inj_burst) ? inj_last : BURST_LEN - 1;
                axi.AXI_rvalid = slave_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
                axi.AXI_rlast  = (beat_idx == last_idx);
                axi.AXI_rresp  = (r_burst_no == inj_burst && beat_idx == inj_resp_beat) ? 2'd2 : 2'd0;
            end else begin
                axi.AXI_rvalid = 1'b0;
                axi.AXI_rlast  = 1'b0;
                axi.AXI_rresp  = 2'd0;
            end
            Oen = cons_force || (cons_en && Ovalid && cons_beats < cons_target &&
                                 (!cons_rand || $urandom_range(0, 3) != 0));
            #2;
            if (!rst) begin
                if (axi.AXI_rvalid && axi.AXI_rready) begin
                    if (a2s_en) mem[a2s_addr] = ar_q[0] + 32'(beat_idx * BEAT_BYTES);
                    else drained++;
                    if (axi.AXI_rlast) begin
                        void'(ar_q.pop_front());
                        beat_idx = 0;
                        r_burst_no++;
                    end else begin
                        beat_idx++;
                    end
                end
                if (axi.AXI_arvalid && axi.AXI_arready) begin
                    ar_q.push_back(axi.AXI_araddr);
                    ar_log.push_back(axi.AXI_araddr);
                end
                if (Oen && Ovalid) begin
                    if (sb_en) check("beat_data", mem[Oaddr], exp_tag(cons_beats));
                    cons_beats++;
                end
            end
        end
    end

    task automatic step();
        @(negedge Sclk);
        #1;
    endtask

    task automatic resync(input logic [31:0] b, input int sz, input bit lp);
        int t = 0;
        cons_en = 0;
        cons_force = 0;
        sync = 1'b1;
        step();
        while ((ar_q.size() != 0 || axi.AXI_arvalid || axi.AXI_rready) && t < 500) begin
            step();
            t++;
        end
        check("resync_drained", t < 500, 1);
        obase = b;
        osize = SIZE_W'(sz);
        loop  = lp;
        step();
        step();
        ar_log.delete();
        cons_beats = 0;
        drained = 0;
        sync = 1'b0;
    endtask

    typedef struct {
        logic [31:0] base;
        int          size;
        bit          lp;
        int          nburst;
        bit          rnd;
        int          exp_obcnt;
        int          exp_oacnt;
        bit          exp_done;
    } vec_t;

    initial begin
        vec_t vecs[5];
        int t;
        vecs[0] = '{32'h0000_0000, 4, 1'b0, 4, 1'b0, 1, 0, 1'b1};
        vecs[1] = '{32'h1000_0010, 1, 1'b0, 1, 1'b1, 1, 0, 1'b1};
        vecs[2] = '{32'h0000_0000, 2, 1'b1, 6, 1'b1, 3, 0, 1'b0};
        vecs[3] = '{32'hFFFF_FFC0, 3, 1'b1, 7, 1'b1, 2, 1, 1'b0};
        vecs[4] = '{32'h0000_0400, 0, 1'b0, 0, 1'b0, 0, 0, 1'b1};

        rst = 1'b1; sync = 1'b0; obase = 32'h0; osize = SIZE_W'(4); loop = 1'b0;
        repeat (3) step();
        check("rst_ovalid", Ovalid, 0);
        check("rst_oaddr", Oaddr, 0);
        check("rst_oacnt", oacnt, 0);
        check("rst_obcnt", obcnt, 0);
        check("rst_underrun", underrun, 0);
        check("rst_err", err, 0);
        check("rst_done", done, 0);
        check("rst_arvalid", axi.AXI_arvalid, 0);
        check("rst_rready", axi.AXI_rready, 0);
        check("arlen", axi.AXI_arlen, 15);
        check("arsize", axi.AXI_arsize, 2);
        check("arburst", axi.AXI_arburst, 1);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            resync(vecs[i].base, vecs[i].size, vecs[i].lp);
            slave_rand  = vecs[i].rnd;
            cons_rand   = vecs[i].rnd;
            sb_en       = 1;
            cons_target = vecs[i].nburst * BURST_LEN;
            cons_en     = 1;
            t = 0;
            while (cons_beats < cons_target && t < 4000) begin
                step();
                t++;
            end
            check($sformatf("v%0d_complete", i), t < 4000, 1);
            repeat (50) step();
            check($sformatf("v%0d_obcnt", i), obcnt, vecs[i].exp_obcnt);
            check($sformatf("v%0d_oacnt", i), oacnt, vecs[i].exp_oacnt);
            check($sformatf("v%0d_done", i), done, vecs[i].exp_done);
            check($sformatf("v%0d_underrun", i), underrun, 0);
            check($sformatf("v%0d_err", i), err, 0);
            if (vecs[i].lp) check($sformatf("v%0d_ar_cnt_min", i), ar_log.size() >= vecs[i].nburst, 1);
            else            check($sformatf("v%0d_ar_cnt", i), ar_log.size(), vecs[i].size);
            for (int k = 0; k < ar_log.size(); k++)
                check($sformatf("v%0d_araddr%0d", i, k), ar_log[k], exp_ar(k));
            cons_en = 0;
        end
        slave_rand = 0;
        cons_rand  = 0;

        // Consumer stalled: credit allows exactly NBUF fetches, one more after a release
        resync(32'h2000, 8, 1'b0);
        repeat (200) step();
        check("stall_ar_cnt", ar_log.size(), NBUF);
        check("stall_ovalid", Ovalid, 1);
        cons_target = BURST_LEN;
        cons_en = 1;
        t = 0;
        while (cons_beats < cons_target && t < 500) begin step(); t++; end
        check("stall_consumed", t < 500, 1);
        repeat (60) step();
        check("stall_ar_cnt_after", ar_log.size(), NBUF + 1);
        if (ar_log.size() > NBUF) check("stall_5th_addr", ar_log[NBUF], 32'h2100);

        // Underrun with an empty buffer
        resync(32'h0, 0, 1'b0);
        cons_force = 1;
        repeat (3) step();
        cons_force = 0;
        step();
        check("underrun_set", underrun, 1);
        check("underrun_oaddr", Oaddr, 0);
        check("underrun_ovalid", Ovalid, 0);
        sync = 1'b1; step(); sync = 1'b0; step();
        check("underrun_cleared", underrun, 0);

        // Restart while the 5th beat of the second burst is on the bus
        resync(32'h3000, 4, 1'b0);
        t = 0;
        while (!(ar_log.size() == 2 && beat_idx == 4 && axi.AXI_rvalid) && t < 500) begin step(); t++; end
        check("drain_found_beat", t < 500, 1);
        sync = 1'b1;
        step();
        sync = 1'b0;
        check("drain_ovalid", Ovalid, 0);
        check("drain_oaddr", Oaddr, 0);
        t = 0;
        while (ar_log.size() < 3 && t < 500) begin step(); t++; end
        check("drain_reissue", t < 500, 1);
        check("drain_absorbed", drained, BURST_LEN - 5);
        if (ar_log.size() >= 3) check("drain_next_addr", ar_log[2], 32'h3000);
        check("drain_err", err, 0);

        // Error response plus early rlast: err sticky, slot still handed over
        resync(32'h4000, 4, 1'b0);
        inj_burst = r_burst_no;
        inj_resp_beat = 3;
        inj_last = 14;
        sb_en = 0;
        t = 0;
        while (!Ovalid && t < 500) begin step(); t++; end
        check("err_slot_valid", Ovalid, 1);
        check("err_set", err, 1);
        cons_target = BURST_LEN;
        cons_en = 1;
        t = 0;
        while (cons_beats < cons_target && t < 500) begin step(); t++; end
        check("err_consumed", t < 500, 1);
        repeat (3) step();
        check("err_oacnt", oacnt, 1);
        check("err_sticky", err, 1);
        inj_burst = -1;
        resync(32'h0, 4, 1'b0);
        check("err_cleared", err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end
endmodule
